// File: rtl/dm_pkg.sv
// dm_pkg: data-memory op codes, alignment helpers and arbiter state type
package dm_pkg;
  localparam logic [2:0] DM_LW  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LHU = 3'b010;
  localparam logic [2:0] DM_LB  = 3'b011;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_SW  = 3'b101;
  localparam logic [2:0] DM_SH  = 3'b110;
  localparam logic [2:0] DM_SB  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} dm_arb_state_t;
  function automatic logic is_store(input logic [2:0] op);
    return op inside {DM_SW, DM_SH, DM_SB};
  endfunction
  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] a);
    return (op == DM_LW || op == DM_SW) ? (a == 2'b00) :
           (op inside {DM_LH, DM_LHU, DM_SH}) ? !a[0] : 1'b1;
  endfunction
endpackage

// File: rtl/dm_arb_if.sv
// dm_arb_if: requester handshakes and data-memory bus of the arbiter
interface dm_arb_if #(parameter int ADDR_W = 7);
  logic              req0, req1;
  logic [2:0]        op0, op1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0]       rdata0, rdata1;
  logic              mem_wr;
  logic [2:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;
  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
           mem_wr, mem_op, mem_addr, mem_din
  );
  modport master (
    output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
           mem_wr, mem_op, mem_addr, mem_din
  );
endinterface

// File: rtl/dm_rr2.sv
// dm_rr2: two-way round-robin picker; pointer moves to the loser on each grant
module dm_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       adv,
  output logic [1:0] pick,
  output logic       any
);
  logic rr_q, rr_d;
  always_comb begin
    any  = req0 | req1;
    pick = (req0 & req1) ? (rr_q ? 2'b10 : 2'b01) : {req1, req0};
    rr_d = (adv & any) ? pick[0] : rr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
endmodule

// File: rtl/dm_arb.sv
// dm_arb: round-robin two-port arbiter and one-cycle sequencer for the data memory
module dm_arb
  import dm_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input logic     clk,
  input logic     rst,
  dm_arb_if.slave bus
);
  dm_arb_state_t     state_q, state_d;
  logic [1:0]        pick;
  logic              any, adv, acc, ok, st, ld;
  logic              sel_q, sel_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign adv = (state_q != ST_ACCESS) & any;

  dm_rr2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .adv  (adv),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;

  always_comb
    state_d = (state_q == ST_ACCESS) ? ST_RESP : (any ? ST_ACCESS : ST_IDLE);

  // memory lines are decoded straight from state so a reset in ACCESS drops a store at once
  always_comb begin
    sel_d     = adv ? pick[1] : sel_q;
    op_d      = adv ? (pick[1] ? bus.op1 : bus.op0) : op_q;
    addr_d    = adv ? (pick[1] ? bus.addr1 : bus.addr0) : addr_q;
    wdata_d   = adv ? (pick[1] ? bus.wdata1 : bus.wdata0) : wdata_q;
    gnt0_d    = adv & pick[0];
    gnt1_d    = adv & pick[1];
    acc       = state_q == ST_ACCESS;
    ok        = is_aligned(op_q, addr_q[1:0]);
    st        = acc & ok & is_store(op_q);
    ld        = acc & ok & !is_store(op_q);
    rvalid0_d = acc & !sel_q;
    rvalid1_d = acc & sel_q;
    err0_d    = rvalid0_d & !ok;
    err1_d    = rvalid1_d & !ok;
    rdata0_d  = (ld & !sel_q) ? bus.mem_dout : 32'h0;
    rdata1_d  = (ld & sel_q) ? bus.mem_dout : 32'h0;
    bus.mem_op   = (acc & ok) ? op_q : DM_LW;
    bus.mem_wr   = st;
    bus.mem_addr = (acc & ok) ? addr_q : '0;
    bus.mem_din  = st ? wdata_q : 32'h0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q     <= 1'b0;
      op_q      <= DM_LW;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      sel_q     <= sel_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
endmodule
